// File: rtl/camera_frame_source_if.sv
// camera_frame_source_if
// Parallel camera video bus as seen on the camera connector.
//   PCLK  : pixel clock (byte strobe, data stable across its rising edge)
//   HREF  : high while active bytes of a line are on DATA
//   VSYNC : high during the vertical sync period
//   DATA  : one byte of an RGB565 pixel, high byte first
// master = the camera (or its emulator), slave = the capture logic.
interface camera_frame_source_if;
  logic       PCLK;
  logic       HREF;
  logic       VSYNC;
  logic [7:0] DATA;

  modport master (output PCLK, output HREF, output VSYNC, output DATA);
  modport slave  (input  PCLK, input  HREF, input  VSYNC, input  DATA);
endinterface

// File: rtl/camera_frame_source.sv
// camera_frame_source
// Emulates the camera's parallel video output so the capture path can be
// brought up without the sensor. Frames are built from internal test patterns
// (solid, colour bars, gradient, checker) and sent as RGB565, high byte first.
//
// Ports:
//   CLK        system clock; PCLK runs at CLK/2
//   RESET_N    asynchronous active-low reset, aborts any frame in progress
//   EN         allows a new frame to start at the next slot boundary
//   MODE       pattern select, latched at frame start
//   COLOR      solid-mode RGB565 value, latched at frame start
//   cam        camera bus (PCLK, HREF, VSYNC, DATA), master side
//   FRAME_DONE one-CLK pulse on the edge that ends the last front-porch slot
//
// A "slot" is one byte time (2 CLK). Everything except PCLK changes only on the
// CLK edge that drives PCLK low, so the capture side sees stable values on the
// PCLK rising edge.
module camera_frame_source #(
  parameter int WIDTH    = 176,
  parameter int HEIGHT   = 144,
  parameter int H_BLANK  = 32,
  parameter int VS_LINES = 3,
  parameter int VB_LINES = 10,
  parameter int VF_LINES = 5
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          EN,
  input  logic [1:0]                    MODE,
  input  logic [15:0]                   COLOR,
  camera_frame_source_if.master         cam,
  output logic                          FRAME_DONE
);

  localparam int LINE_SLOTS = 2 * WIDTH + H_BLANK;
  // +1 keeps 2*WIDTH representable even when H_BLANK = 0
  localparam int SLOT_W     = $clog2(LINE_SLOTS + 1);
  localparam int ML_A       = (VS_LINES > VB_LINES) ? VS_LINES : VB_LINES;
  localparam int ML_B       = (HEIGHT > VF_LINES) ? HEIGHT : VF_LINES;
  localparam int MAX_LINES  = (ML_A > ML_B) ? ML_A : ML_B;
  localparam int LINE_W     = $clog2(MAX_LINES + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST    = SLOT_W'(LINE_SLOTS - 1);
  localparam logic [SLOT_W-1:0] ACTIVE_SLOTS = SLOT_W'(2 * WIDTH);
  localparam logic [15:0]       BAR_W        = 16'(WIDTH / 8);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic                phase_r;
  logic [SLOT_W-1:0]   slot_r;
  logic [SLOT_W-1:0]   slot_nx_s;
  logic [LINE_W-1:0]   line_r;
  logic [LINE_W-1:0]   line_nx_s;
  logic [LINE_W-1:0]   line_last_s;
  logic                latch_s;
  logic                done_s;
  logic [1:0]          mode_r;
  logic [15:0]         color_r;
  logic                href_nx_s;
  logic                vsync_nx_s;
  logic [7:0]          data_nx_s;
  logic [15:0]         px_s;
  logic [5:0]          ln_s;
  logic [15:0]         pix_s;
  logic                href_r;
  logic                vsync_r;
  logic [7:0]          data_r;
  logic                frame_done_r;

  // Slot boundaries are the edges where phase is 1 (PCLK falling).
  logic boundary_s;
  assign boundary_s = phase_r;

  // RGB565 test-pattern pixel at column px of active line ln.
  function automatic logic [15:0] pattern_pixel(input logic [1:0]  mode,
                                                input logic [15:0] color,
                                                input logic [15:0] px,
                                                input logic [5:0]  ln);
    logic [15:0] pix;
    logic [15:0] bar;
    bar = px / BAR_W;
    case (mode)
      2'd0: pix = color;
      2'd1: begin
        case (bar)
          16'd0:   pix = 16'hFFFF;
          16'd1:   pix = 16'hFFE0;
          16'd2:   pix = 16'h07FF;
          16'd3:   pix = 16'h07E0;
          16'd4:   pix = 16'hF81F;
          16'd5:   pix = 16'hF800;
          16'd6:   pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd2:    pix = {px[4:0], ln[5:0], px[4:0]};
      2'd3:    pix = (px[3] ^ ln[3]) ? 16'hFFFF : 16'h0000;
      default: pix = 16'h0000;
    endcase
    return pix;
  endfunction

  // PCLK phase: free-running toggle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      phase_r <= 1'b0;
    end else begin
      phase_r <= ~phase_r;
    end
  end

  // Index of the last line in the current vertical state.
  always_comb begin
    line_last_s = {LINE_W{1'b0}};
    case (state_r)
      ST_VSYNC:  line_last_s = LINE_W'(VS_LINES - 1);
      ST_VBACK:  line_last_s = LINE_W'(VB_LINES - 1);
      ST_ACTIVE: line_last_s = LINE_W'(HEIGHT - 1);
      ST_VFRONT: line_last_s = LINE_W'(VF_LINES - 1);
      default:   line_last_s = {LINE_W{1'b0}};
    endcase
  end

  // FSM next state and slot/line counter advance.
  always_comb begin
    state_nx_s = state_r;
    slot_nx_s  = slot_r;
    line_nx_s  = line_r;
    latch_s    = 1'b0;
    done_s     = 1'b0;
    if (boundary_s) begin
      if (state_r == ST_IDLE) begin
        if (EN) begin
          state_nx_s = ST_VSYNC;
          latch_s    = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end else if (slot_r != SLOT_LAST) begin
        slot_nx_s = slot_r + SLOT_W'(1);
      end else begin
        slot_nx_s = {SLOT_W{1'b0}};
        if (line_r != line_last_s) begin
          line_nx_s = line_r + LINE_W'(1);
        end else begin
          line_nx_s = {LINE_W{1'b0}};
          case (state_r)
            ST_VSYNC:  state_nx_s = ST_VBACK;
            ST_VBACK:  state_nx_s = ST_ACTIVE;
            ST_ACTIVE: state_nx_s = ST_VFRONT;
            ST_VFRONT: begin
              // Frame ends here; a pending EN chains straight into the next sync.
              done_s = 1'b1;
              if (EN) begin
                state_nx_s = ST_VSYNC;
                latch_s    = 1'b1;
              end else begin
                state_nx_s = ST_IDLE;
              end
            end
            default:   state_nx_s = ST_IDLE;
          endcase
        end
      end
    end else begin
      state_nx_s = state_r;
    end
  end

  // Output decode from the state/counters that take effect at this edge.
  always_comb begin
    href_nx_s  = 1'b0;
    vsync_nx_s = 1'b0;
    data_nx_s  = 8'h00;
    px_s       = 16'(slot_nx_s) >> 1;
    ln_s       = 6'(line_nx_s);
    pix_s      = pattern_pixel(mode_r, color_r, px_s, ln_s);
    vsync_nx_s = (state_nx_s == ST_VSYNC);
    if ((state_nx_s == ST_ACTIVE) && (slot_nx_s < ACTIVE_SLOTS)) begin
      href_nx_s = 1'b1;
      data_nx_s = slot_nx_s[0] ? pix_s[7:0] : pix_s[15:8];
    end else begin
      href_nx_s = 1'b0;
      data_nx_s = 8'h00;
    end
  end

  // FSM state and counters register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
      slot_r  <= {SLOT_W{1'b0}};
      line_r  <= {LINE_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      slot_r  <= slot_nx_s;
      line_r  <= line_nx_s;
    end
  end

  // Pattern configuration captured at frame start, held for the whole frame.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_r  <= 2'd0;
      color_r <= 16'h0000;
    end else if (latch_s) begin
      mode_r  <= MODE;
      color_r <= COLOR;
    end
  end

  // Registered camera outputs and end-of-frame pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      href_r       <= 1'b0;
      vsync_r      <= 1'b0;
      data_r       <= 8'h00;
      frame_done_r <= 1'b0;
    end else begin
      href_r       <= href_nx_s;
      vsync_r      <= vsync_nx_s;
      data_r       <= data_nx_s;
      frame_done_r <= done_s;
    end
  end

  assign cam.PCLK  = phase_r;
  assign cam.HREF  = href_r;
  assign cam.VSYNC = vsync_r;
  assign cam.DATA  = data_r;
  assign FRAME_DONE = frame_done_r;

endmodule
